// File: rtl/eval_sram_to_sram_pkg.sv
// eval_sram_to_sram_pkg: shared FSM state type and default widths for the SRAM copy core
package eval_sram_to_sram_pkg;
    localparam int DEF_ADDR_BITS  = 10;
    localparam int DEF_DATA_BITS  = 64;
    localparam int DEF_LEN_BITS   = 11;
    localparam int DEF_CYCLE_BITS = 32;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
endpackage

// File: rtl/eval_sram_to_sram_copy_core_if.sv
// eval_sram_to_sram_copy_core_if: control, status and SRAM port bundle of the copy core
interface eval_sram_to_sram_copy_core_if
    import eval_sram_to_sram_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int LEN_BITS   = DEF_LEN_BITS,
    parameter int CYCLE_BITS = DEF_CYCLE_BITS
) ();
    logic                  ctl_start;
    logic [ADDR_BITS-1:0]  ctl_src_addr;
    logic [ADDR_BITS-1:0]  ctl_dst_addr;
    logic [LEN_BITS-1:0]   ctl_len;
    logic                  stat_busy;
    logic                  stat_done;
    logic                  stat_done_pulse;
    logic [CYCLE_BITS-1:0] stat_cycles;
    logic                  src_en;
    logic [ADDR_BITS-1:0]  src_addr;
    logic [DATA_BITS-1:0]  src_rdata;
    logic                  dst_we;
    logic [ADDR_BITS-1:0]  dst_addr;
    logic [DATA_BITS-1:0]  dst_wdata;

    modport slave (
        input  ctl_start, ctl_src_addr, ctl_dst_addr, ctl_len, src_rdata,
        output stat_busy, stat_done, stat_done_pulse, stat_cycles,
               src_en, src_addr, dst_we, dst_addr, dst_wdata
    );
    modport master (
        output ctl_start, ctl_src_addr, ctl_dst_addr, ctl_len, src_rdata,
        input  stat_busy, stat_done, stat_done_pulse, stat_cycles,
               src_en, src_addr, dst_we, dst_addr, dst_wdata
    );
endinterface

// File: rtl/eval_sram_to_sram_valid_delay.sv
// eval_sram_to_sram_valid_delay: DEPTH-stage read-valid shift register with in-flight flag
module eval_sram_to_sram_valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic valid_o,
    output logic pending_o
);
    logic [DEPTH-1:0] v_q, v_d;

    // Shift in the new valid; the top bit leaves on the cycle its data is presented
    assign v_d       = DEPTH'({v_q, valid_i});
    assign valid_o   = v_q[DEPTH-1];
    assign pending_o = |v_d;

    // Pipeline register, cleared by reset so no write survives it
    always_ff @(posedge clk_i) begin
        v_q <= rst_i ? '0 : v_d;
    end
endmodule

// File: rtl/eval_sram_to_sram_copy_core.sv
// eval_sram_to_sram_copy_core: streams len words from a source SRAM to a destination SRAM
module eval_sram_to_sram_copy_core
    import eval_sram_to_sram_pkg::*;
#(
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int LEN_BITS   = DEF_LEN_BITS,
    parameter int RD_LATENCY = 2,
    parameter int CYCLE_BITS = DEF_CYCLE_BITS
) (
    input logic                         core_clk,
    input logic                         core_reset,
    eval_sram_to_sram_copy_core_if.slave bus
);
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(2 ** ADDR_BITS);

    state_t                state_q, state_d;
    logic [LEN_BITS-1:0]   rem_q, rem_d, len_clamped;
    logic [ADDR_BITS-1:0]  src_q, src_d, dst_q, dst_d;
    logic [CYCLE_BITS-1:0] cyc_q, cyc_d;
    logic                  done_q, done_d;
    logic                  rd, wr, pending, busy;

    eval_sram_to_sram_valid_delay #(.DEPTH(RD_LATENCY)) u_valid (
        .clk_i     (core_clk),
        .rst_i     (core_reset),
        .valid_i   (rd),
        .valid_o   (wr),
        .pending_o (pending)
    );

    assign rd  = state_q == READ;
    assign busy = rd || state_q == DRAIN;

    assign bus.src_en          = rd;
    assign bus.src_addr        = src_q;
    assign bus.dst_we          = wr;
    assign bus.dst_addr        = dst_q;
    assign bus.dst_wdata       = bus.src_rdata;
    assign bus.stat_busy       = busy;
    assign bus.stat_done       = done_q;
    assign bus.stat_done_pulse = state_q == FIN;
    assign bus.stat_cycles     = cyc_q;

    // Next-state: start only accepted in IDLE, addresses walk up, cycle count saturates
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cyc_d       = cyc_q;
        done_d      = done_q;
        len_clamped = bus.ctl_len > MAX_LEN ? MAX_LEN : bus.ctl_len;
        if (state_q == IDLE && bus.ctl_start) begin
            src_d   = bus.ctl_src_addr;
            dst_d   = bus.ctl_dst_addr;
            rem_d   = len_clamped;
            cyc_d   = '0;
            done_d  = 1'b0;
            state_d = len_clamped == '0 ? FIN : READ;
        end
        if (rd) begin
            src_d = src_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == LEN_BITS'(1)) state_d = DRAIN;
        end
        if (state_q == DRAIN && !pending) state_d = FIN;
        if (state_q == FIN) state_d = IDLE;
        if (state_d == FIN) done_d = 1'b1;
        if (wr) dst_d = dst_q + 1'b1;
        if (busy && cyc_q != '1) cyc_d = cyc_q + 1'b1;
    end

    // State and datapath registers
    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            cyc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
        end
    end
endmodule
